// File: rtl/encoder_8x3_seq.sv
// encoder_8x3_seq: registered 8-to-3 priority encoder over a pending-request register.
// Each accepted index is retired. A request for a bit that is already pending merges into it and raises dropped.
module encoder_8x3_seq #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_d,
    input  logic       i_ready,
    output logic [2:0] o_y,
    output logic       o_valid,
    output logic [7:0] o_pend,
    output logic [3:0] o_count,
    output logic       o_dropped
);
    logic [7:0] r_pend;
    logic       r_dropped;
    logic [7:0] w_req;
    logic [7:0] w_clr;
    logic       w_accept;
    logic [2:0] w_y;
    logic [3:0] w_count;

    assign w_req    = i_en ? i_d : 8'h00;
    assign w_accept = o_valid & i_ready;
    assign w_clr    = w_accept ? (8'h01 << w_y) : 8'h00;

    // Later hits overwrite earlier ones, so the scan order selects the priority.
    always_comb begin
        w_y = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (r_pend[i]) w_y = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (r_pend[i]) w_y = 3'(i);
        end
    end

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 8; i++)
            w_count = w_count + 4'(r_pend[i]);
    end

    // A request on the bit being cleared keeps it pending and is not a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 8'h00;
            r_dropped <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_clr) | w_req;
            r_dropped <= |(w_req & r_pend & ~w_clr);
        end
    end

    assign o_y       = w_y;
    assign o_valid   = |r_pend;
    assign o_pend    = r_pend;
    assign o_count   = w_count;
    assign o_dropped = r_dropped;
endmodule

// File: doc/encoder_8x3_seq.md
Name: encoder_8x3_seq

Overview:
- Registered 8-to-3 priority encoder with a pending-request queue. It is the encode-side counterpart of the team's 3x8 decoder.
- Up to 8 request lines are captured into a pending register. The block emits the 3-bit index of the highest-priority pending line with a valid/ready handshake, and retires each index once it is accepted.
- It sits between per-line event sources and a consumer that drives the 3x8 decoder downstream.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request capture enable; when 0, d is ignored.
- d  input  8  request lines; multi-hot allowed; sampled each cycle en=1.
- ready  input  1  consumer accepts the current y this cycle.
- y  output  3  encoded index of the highest-priority pending bit.
- valid  output  1  at least one bit is pending; y is meaningful.
- pend  output  8  pending register contents, for observation.
- count  output  4  popcount of pend, range 0..8.
- dropped  output  1  one-cycle pulse: a request hit an already-pending bit and merged.

Behaviour:
- Reset: on a rising edge with rst=1, pend=0, dropped=0. Consequently valid=0, y=3'b000, count=0. rst overrides en, d and ready in the same cycle.
- Handshake:
  - accept = valid & ready.
  - clr = one-hot(y) when accept, else 0.
  - ready while valid=0 has no effect.
- Pending update, every edge with rst=0:
  - req = en ? d : 8'h00.
  - pend <= (pend & ~clr) | req.
- Simultaneous events:
  - A new request on the bit being cleared in the same cycle wins: the bit stays set, and that index is presented again later.
  - New requests on other bits merge normally.
- dropped: registered.
  - dropped <= |(req & pend & ~clr).
  - Asserted the cycle after any merge; an overlap with a bit being cleared that cycle does not count as dropped.
- Outputs y, valid, count: combinational from the pend register only, never from d or ready. Latency from d to valid is 1 cycle.
  - valid = |pend.
  - count = popcount(pend).
  - y = index of the highest-priority set bit per HIGH_FIRST; 3'b000 when pend=0.
- y stability: y stays stable while valid=1 and ready=0, unless a newly captured higher-priority bit preempts it. Preemption is legal; the consumer samples y only in accept cycles.
- Throughput: one index retired per cycle. 8 pending bits with ready held at 1 drain in exactly 8 cycles, absent new requests.
- en=0: the queue continues to drain; no captures and no dropped pulses occur.
- No internal FSM beyond the pend register.
- Each of the 8 bits has two states: IDLE (0) and PENDING (1).
  - IDLE -> PENDING on req[i].
  - PENDING -> IDLE on clr[i] & ~req[i].

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then en=0 and ready=0 for 5 cycles -> pend=00000000, valid=0, y=000, count=0, dropped=0 throughout.
- Single request: en=1, d=00100000 for 1 cycle, ready=0 -> next cycle pend=00100000, valid=1, y=101, count=1. Then ready=1 for 1 cycle -> the following cycle valid=0, pend=0.
- Priority drain, HIGH_FIRST=1: en=1, d=10010010 once, then ready=1 held -> y sequence 111, 100, 001 on consecutive cycles, then valid=0; count steps 3, 2, 1, 0.
- Priority drain, HIGH_FIRST=0: same stimulus -> y sequence 001, 100, 111.
- Merge and simultaneous events:
  - pend=00001000; en=1, d=00001001 with ready=1 (y=011, HIGH_FIRST=1) -> pend=00001001 next cycle, dropped=0 (the clear collided).
  - Repeat with ready=0 -> dropped=1 for exactly one cycle, pend=00001001.
- Reset mid-operation: pend=11111111, ready=1, assert rst for 1 cycle while en=1, d=11111111 -> next cycle pend=0, valid=0, count=0, dropped=0.
